// File: rtl/keypad_link.sv
// Keypad link: receives 4-bit status frames from the alarm main module and
// forwards locally scanned key digits to it through a 4-entry FIFO.
module keypad_link #(
    parameter int GAP          = 2,
    parameter int LINK_TIMEOUT = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       STATUS_IN,
    input  logic       STATUS_SEND,
    input  logic       key_valid,
    input  logic [1:0] key_code,
    output logic [1:0] KB_OUT,
    output logic       KB_SEND,
    output logic       armed,
    output logic       alarm,
    output logic       sensor1,
    output logic       sensor2,
    output logic       status_valid,
    output logic       frame_err,
    output logic       link_lost,
    output logic       key_overflow,
    output logic [2:0] o_dbg_rx_state,
    output logic [1:0] o_dbg_tx_state
);

    // Handshakes: key_valid is a one-cycle push with no backpressure (a key
    // arriving at a full FIFO is dropped and flagged); KB_SEND qualifies
    // KB_OUT for exactly one cycle; status_valid qualifies the status bits.

    localparam logic [7:0] TIMEOUT_LIMIT = 8'(LINK_TIMEOUT);
    localparam logic [2:0] GAP_LAST      = 3'(GAP - 1);

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_BIT0,
        RX_BIT1,
        RX_BIT2,
        RX_BIT3
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_SEND,
        TX_GAP
    } tx_state_t;

    rx_state_t   r_rx_state;
    rx_state_t   w_rx_next;
    logic        w_rx_abort;
    logic        w_rx_done;
    logic [2:0]  r_shift;
    logic [3:0]  r_status;
    logic        r_status_valid;
    logic        r_frame_err;
    logic [7:0]  r_to_cnt;

    tx_state_t   r_tx_state;
    tx_state_t   w_tx_next;
    logic        w_pop;
    logic        w_push;
    logic [1:0]  r_mem [4];
    logic [1:0]  r_wr_ptr;
    logic [1:0]  r_rd_ptr;
    logic [2:0]  r_count;
    logic [2:0]  r_gap_cnt;
    logic [1:0]  r_kb_out;
    logic        r_kb_send;
    logic        r_key_overflow;

    // ---------------- status receiver ----------------
    always_comb begin
        w_rx_next  = r_rx_state;
        w_rx_abort = 1'b0;
        w_rx_done  = 1'b0;
        case (r_rx_state)
            RX_IDLE: if (STATUS_SEND) w_rx_next = RX_BIT0;
            RX_BIT0: w_rx_next = RX_BIT1;
            RX_BIT1: w_rx_next = RX_BIT2;
            RX_BIT2: w_rx_next = RX_BIT3;
            RX_BIT3: begin
                w_rx_next = RX_IDLE;
                w_rx_done = 1'b1;
            end
            default: w_rx_next = RX_IDLE;
        endcase
        // A strobe inside a frame aborts it and is itself a new frame start.
        if (STATUS_SEND && (r_rx_state != RX_IDLE)) begin
            w_rx_next  = RX_BIT0;
            w_rx_abort = 1'b1;
            w_rx_done  = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_rx_state     <= RX_IDLE;
            r_shift        <= 3'd0;
            r_status       <= 4'd0;
            r_status_valid <= 1'b0;
            r_frame_err    <= 1'b0;
        end else begin
            r_rx_state     <= w_rx_next;
            r_status_valid <= w_rx_done;
            r_frame_err    <= w_rx_abort;
            case (r_rx_state)
                RX_BIT0: r_shift[0] <= STATUS_IN;
                RX_BIT1: r_shift[1] <= STATUS_IN;
                RX_BIT2: r_shift[2] <= STATUS_IN;
                default: ;
            endcase
            if (w_rx_done) r_status <= {STATUS_IN, r_shift};
        end
    end

    // Cycles since the last frame start; saturates at the timeout value.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_to_cnt <= 8'd0;
        end else if (STATUS_SEND) begin
            r_to_cnt <= 8'd0;
        end else if (r_to_cnt != TIMEOUT_LIMIT) begin
            r_to_cnt <= r_to_cnt + 8'd1;
        end
    end

    // ---------------- key transmitter ----------------
    // The last gap cycle may pop directly so strobes are GAP+1 cycles apart.
    always_comb begin
        w_tx_next = r_tx_state;
        w_pop     = 1'b0;
        case (r_tx_state)
            TX_IDLE: begin
                if (r_count != 3'd0) begin
                    w_pop     = 1'b1;
                    w_tx_next = TX_SEND;
                end
            end
            TX_SEND: w_tx_next = TX_GAP;
            TX_GAP: begin
                if (r_gap_cnt == GAP_LAST) begin
                    if (r_count != 3'd0) begin
                        w_pop     = 1'b1;
                        w_tx_next = TX_SEND;
                    end else begin
                        w_tx_next = TX_IDLE;
                    end
                end
            end
            default: w_tx_next = TX_IDLE;
        endcase
    end

    assign w_push = key_valid && ((r_count != 3'd4) || w_pop);

    always_ff @(posedge CLK) begin
        if (w_push) r_mem[r_wr_ptr] <= key_code;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_tx_state     <= TX_IDLE;
            r_wr_ptr       <= 2'd0;
            r_rd_ptr       <= 2'd0;
            r_count        <= 3'd0;
            r_gap_cnt      <= 3'd0;
            r_kb_out       <= 2'd0;
            r_kb_send      <= 1'b0;
            r_key_overflow <= 1'b0;
        end else begin
            r_tx_state     <= w_tx_next;
            r_gap_cnt      <= (r_tx_state == TX_GAP) ? r_gap_cnt + 3'd1 : 3'd0;
            r_kb_send      <= w_pop;
            r_key_overflow <= key_valid && (r_count == 3'd4) && !w_pop;
            if (w_pop) begin
                r_kb_out <= r_mem[r_rd_ptr];
                r_rd_ptr <= r_rd_ptr + 2'd1;
            end
            if (w_push) r_wr_ptr <= r_wr_ptr + 2'd1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: ;
            endcase
        end
    end

    // ---------------- outputs ----------------
    assign {sensor2, sensor1, alarm, armed} = r_status;
    assign status_valid   = r_status_valid;
    assign frame_err      = r_frame_err;
    assign link_lost      = (r_to_cnt == TIMEOUT_LIMIT);
    assign KB_OUT         = r_kb_out;
    assign KB_SEND        = r_kb_send;
    assign key_overflow   = r_key_overflow;
    assign o_dbg_rx_state = r_rx_state;
    assign o_dbg_tx_state = r_tx_state;

endmodule

// File: tb/tb_keypad_link.sv
// Bench for keypad_link: two instances (GAP=2/timeout 16 and GAP=7/timeout 8)
// share stimulus; expectations come from an event-level model and queues.
module tb_keypad_link;

    localparam int GAP_A = 2;
    localparam int GAP_B = 7;
    localparam int LT_A  = 16;
    localparam int LT_B  = 8;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       STATUS_IN = 1'b0;
    logic       STATUS_SEND = 1'b0;
    logic       key_valid = 1'b0;
    logic [1:0] key_code = 2'd0;

    logic [1:0] KB_OUT;
    logic       KB_SEND, armed, alarm, sensor1, sensor2;
    logic       status_valid, frame_err, link_lost, key_overflow;
    logic [2:0] dbg_rx_a;
    logic [1:0] dbg_tx_a;

    logic [1:0] b_kb_out;
    logic       b_kb_send, b_armed, b_alarm, b_sensor1, b_sensor2;
    logic       b_status_valid, b_frame_err, b_link_lost, b_key_overflow;
    logic [2:0] dbg_rx_b;
    logic [1:0] dbg_tx_b;

    keypad_link #(.GAP(GAP_A), .LINK_TIMEOUT(LT_A)) dut (
        .CLK(CLK), .RST(RST), .STATUS_IN(STATUS_IN), .STATUS_SEND(STATUS_SEND),
        .key_valid(key_valid), .key_code(key_code),
        .KB_OUT(KB_OUT), .KB_SEND(KB_SEND),
        .armed(armed), .alarm(alarm), .sensor1(sensor1), .sensor2(sensor2),
        .status_valid(status_valid), .frame_err(frame_err),
        .link_lost(link_lost), .key_overflow(key_overflow),
        .o_dbg_rx_state(dbg_rx_a), .o_dbg_tx_state(dbg_tx_a)
    );

    keypad_link #(.GAP(GAP_B), .LINK_TIMEOUT(LT_B)) dut_b (
        .CLK(CLK), .RST(RST), .STATUS_IN(STATUS_IN), .STATUS_SEND(STATUS_SEND),
        .key_valid(key_valid), .key_code(key_code),
        .KB_OUT(b_kb_out), .KB_SEND(b_kb_send),
        .armed(b_armed), .alarm(b_alarm), .sensor1(b_sensor1), .sensor2(b_sensor2),
        .status_valid(b_status_valid), .frame_err(b_frame_err),
        .link_lost(b_link_lost), .key_overflow(b_key_overflow),
        .o_dbg_rx_state(dbg_rx_b), .o_dbg_tx_state(dbg_tx_b)
    );

    // ---------------- clock / cycle count ----------------
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
        end
    endtask

    // ---------------- scoreboard queues ----------------
    logic [35:0] st_q[$];        // {cycle, status nibble}
    int          fe_q[$];        // frame_err cycles
    logic [33:0] kb_q[2][$];     // {cycle, digit} per instance
    int          ovf_q[2][$];    // key_overflow cycles per instance

    // ---------------- reference model ----------------
    int         fs = -1;         // cycle of current frame start, -1 when none
    logic [3:0] fbits;
    int         pops[2][$];      // pop cycles of accepted keys not yet popped
    int         last_send[2];

    task automatic model_reset();
        fs = -1;
        for (int g = 0; g < 2; g++) begin
            pops[g].delete();
            last_send[g] = -100;
        end
    endtask

    task automatic rx_model(input int c, input logic ss, input logic si);
        if (ss) begin
            if (fs >= 0) fe_q.push_back(c + 1);
            fs = c;
        end else if (fs >= 0) begin
            fbits[c - fs - 1] = si;
            if (c - fs == 4) begin
                st_q.push_back({32'(c + 1), fbits});
                fs = -1;
            end
        end
    endtask

    // A key is accepted if fewer than 4 are waiting or one leaves this cycle;
    // it leaves at the later of (next cycle) and (last strobe + GAP), and is
    // strobed one cycle after leaving.
    task automatic key_model(input int c, input logic [1:0] code);
        for (int g = 0; g < 2; g++) begin
            int gap;
            int p;
            bit pop_now;
            gap = (g == 0) ? GAP_A : GAP_B;
            while (pops[g].size() > 0 && pops[g][0] < c) void'(pops[g].pop_front());
            pop_now = (pops[g].size() > 0) && (pops[g][0] == c);
            if (pops[g].size() < 4 || pop_now) begin
                p = (c + 1 > last_send[g] + gap) ? c + 1 : last_send[g] + gap;
                last_send[g] = p + 1;
                pops[g].push_back(p);
                kb_q[g].push_back({32'(p + 1), code});
            end else begin
                ovf_q[g].push_back(c + 1);
            end
        end
    endtask

    // ---------------- driver ----------------
    task automatic drive(input logic rst, input logic ss, input logic si,
                         input logic kv, input logic [1:0] kc);
        @(posedge CLK);
        #1;
        RST = rst; STATUS_SEND = ss; STATUS_IN = si; key_valid = kv; key_code = kc;
        if (rst) begin
            model_reset();
        end else begin
            rx_model(cyc, ss, si);
            if (kv) key_model(cyc, kc);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    endtask

    task automatic frame(input logic [3:0] b);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, b[i], 1'b0, 2'd0);
    endtask

    function automatic bit queues_empty();
        return st_q.size() == 0 && fe_q.size() == 0 &&
               kb_q[0].size() == 0 && kb_q[1].size() == 0 &&
               ovf_q[0].size() == 0 && ovf_q[1].size() == 0;
    endfunction

    // ---------------- monitor ----------------
    logic [3:0] held_st = 4'd0;
    logic [1:0] kb_held[2] = '{2'd0, 2'd0};
    int         zero_cyc = 1;    // cycle at which the link counter reads 0

    always @(negedge CLK) begin
        int c;
        logic [35:0] se;
        logic [33:0] ke;
        c = cyc;
        if (c >= 1) begin
            if (st_q.size() > 0 && st_q[0][35:4] == 32'(c)) begin
                se = st_q.pop_front();
                chk("status_valid", 32'(status_valid), 32'd1);
                held_st = se[3:0];
            end else begin
                chk("status_valid", 32'(status_valid), 32'd0);
            end
            chk("status_bits", 32'({sensor2, sensor1, alarm, armed}), 32'(held_st));
            if (fe_q.size() > 0 && fe_q[0] == c) begin
                void'(fe_q.pop_front());
                chk("frame_err", 32'(frame_err), 32'd1);
            end else begin
                chk("frame_err", 32'(frame_err), 32'd0);
            end
            chk("link_lost_a", 32'(link_lost), 32'(c - zero_cyc >= LT_A));
            chk("link_lost_b", 32'(b_link_lost), 32'(c - zero_cyc >= LT_B));
            for (int g = 0; g < 2; g++) begin
                logic s;
                logic o;
                logic [1:0] d;
                s = (g == 0) ? KB_SEND : b_kb_send;
                o = (g == 0) ? key_overflow : b_key_overflow;
                d = (g == 0) ? KB_OUT : b_kb_out;
                if (kb_q[g].size() > 0 && kb_q[g][0][33:2] == 32'(c)) begin
                    ke = kb_q[g].pop_front();
                    chk($sformatf("kb_send%0d", g), 32'(s), 32'd1);
                    chk($sformatf("kb_out%0d", g), 32'(d), 32'(ke[1:0]));
                    kb_held[g] = ke[1:0];
                end else begin
                    chk($sformatf("kb_send%0d", g), 32'(s), 32'd0);
                    chk($sformatf("kb_out_hold%0d", g), 32'(d), 32'(kb_held[g]));
                end
                if (ovf_q[g].size() > 0 && ovf_q[g][0] == c) begin
                    void'(ovf_q[g].pop_front());
                    chk($sformatf("key_overflow%0d", g), 32'(o), 32'd1);
                end else begin
                    chk($sformatf("key_overflow%0d", g), 32'(o), 32'd0);
                end
            end
        end
        if (RST) begin
            // Reset abandons everything that would have appeared later.
            while (st_q.size() > 0 && st_q[$][35:4] > 32'(c)) void'(st_q.pop_back());
            while (fe_q.size() > 0 && fe_q[$] > c) void'(fe_q.pop_back());
            for (int g = 0; g < 2; g++) begin
                while (kb_q[g].size() > 0 && kb_q[g][$][33:2] > 32'(c)) void'(kb_q[g].pop_back());
                while (ovf_q[g].size() > 0 && ovf_q[g][$] > c) void'(ovf_q[g].pop_back());
                kb_held[g] = 2'd0;
            end
            held_st  = 4'd0;
            zero_cyc = c + 1;
        end else if (STATUS_SEND) begin
            zero_cyc = c + 1;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int fpos;
        logic ss, si, kv, rst;
        model_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 2'd3);   // inputs during reset are ignored
        idle(22);                               // link timeout after reset

        frame(4'b1101);                         // armed=1 alarm=0 s1=1 s2=1
        idle(3);

        drive(1'b0, 1'b1, 1'b0, 1'b0, 2'd0);   // start, one bit, restart
        drive(1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        idle(3);

        for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b0, 1'b1, 2'(i));
        idle(40);

        for (int i = 0; i < 6; i++) drive(1'b0, 1'b0, 1'b0, 1'b1, 2'(3 - (i % 4)));
        idle(50);

        drive(1'b0, 1'b1, 1'b0, 1'b0, 2'd0);   // reset during bit 2
        drive(1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 2'd2);
        idle(3);
        frame(4'b1010);
        idle(3);

        fpos = 0;
        for (int i = 0; i < 1500; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            kv  = ($urandom_range(0, 2) == 0);
            si  = 1'($urandom_range(0, 1));
            if (fpos == 0) ss = ($urandom_range(0, 9) == 0);
            else           ss = ($urandom_range(0, 24) == 0);
            if (rst)       fpos = 0;
            else if (ss)   fpos = 1;
            else if (fpos > 0) fpos = (fpos == 4) ? 0 : fpos + 1;
            drive(rst, ss, si, kv, 2'($urandom_range(0, 3)));
        end

        for (int i = 0; i < 400 && !queues_empty(); i++) idle(1);
        @(negedge CLK);
        #1;
        chk("st_q_left", 32'(st_q.size()), 32'd0);
        chk("fe_q_left", 32'(fe_q.size()), 32'd0);
        chk("kb_q0_left", 32'(kb_q[0].size()), 32'd0);
        chk("kb_q1_left", 32'(kb_q[1].size()), 32'd0);
        chk("ovf_q0_left", 32'(ovf_q[0].size()), 32'd0);
        chk("ovf_q1_left", 32'(ovf_q[1].size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
